// File: rtl/hbm_channel_rx.sv
// hbm_channel_rx: HBM channel beat receiver with FWFT FIFO, burst tagging and a saturating beat count.
// Optional even-parity checking on received beats is enabled by defining HBM_RX_PARITY_EN.
module hbm_channel_rx #(
    parameter int DATA_WIDTH = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_enable,
    input  logic                  hbm_valid,
    input  logic [DATA_WIDTH-1:0] hbm_dq,
`ifdef HBM_RX_PARITY_EN
    input  logic                  hbm_parity,
    output logic [15:0]           parity_err_count,
`endif
    output logic                  hbm_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [31:0]           beat_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [31:0]           beat_q, beat_d;
    logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q;
    logic                  push, pop, empty, last_in;
`ifdef HBM_RX_PARITY_EN
    logic [15:0]           perr_q, perr_d;
`endif

    // Handshakes and status are decoded from registered state only
    assign empty      = count_q == '0;
    assign hbm_ready  = (state_q == STREAM) && (count_q < CW'(FIFO_DEPTH));
    assign push       = hbm_valid && hbm_ready;
    assign pop        = out_valid && out_ready;
    assign out_valid  = !empty;
    assign out_data   = data_mem_q[rd_ptr_q];
    assign out_last   = !empty && last_mem_q[rd_ptr_q];
    assign busy       = (state_q != IDLE) || !empty;
    assign beat_count = beat_q;
    assign last_in    = burst_q == BW'(BURST_LEN - 1);
`ifdef HBM_RX_PARITY_EN
    assign parity_err_count = perr_q;
`endif

    // Next-state: accept while enabled, then drain buffered beats before idling
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rx_enable ? STREAM : IDLE;
            STREAM:  state_d = rx_enable ? STREAM : DRAIN;
            DRAIN:   state_d = empty ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, occupancy, burst position and saturating counters
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        burst_d  = (state_q != STREAM) ? '0 : push ? (last_in ? '0 : burst_q + BW'(1)) : burst_q;
        beat_d   = beat_q + 32'(push && (beat_q != '1));
`ifdef HBM_RX_PARITY_EN
        perr_d   = perr_q + 16'(push && (^{hbm_dq, hbm_parity}) && (perr_q != '1));
`endif
    end

    // Control registers with synchronous reset; reset discards all buffered beats
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
`ifdef HBM_RX_PARITY_EN
            perr_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
`ifdef HBM_RX_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    // Beat storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= hbm_dq;
            last_mem_q[wr_ptr_q] <= last_in;
        end
    end
endmodule

// File: tb/tb_hbm_channel_rx.sv
// tb_hbm_channel_rx: scoreboard bench for hbm_channel_rx (reset, streaming, full, drain, mid-op reset, parity).
module tb_hbm_channel_rx;
    logic         clk = 1'b0;
    logic         rst, rx_enable, hbm_valid, out_ready;
    logic [255:0] hbm_dq;
    logic         hbm_ready, out_valid, out_last, busy;
    logic [255:0] out_data;
    logic [31:0]  beat_count;
`ifdef HBM_RX_PARITY_EN
    logic         hbm_parity;
    logic [15:0]  parity_err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [256:0] sb[$];
    int bidx = 0;

    hbm_channel_rx dut (
        .clk(clk), .rst(rst), .rx_enable(rx_enable), .hbm_valid(hbm_valid), .hbm_dq(hbm_dq),
`ifdef HBM_RX_PARITY_EN
        .hbm_parity(hbm_parity), .parity_err_count(parity_err_count),
`endif
        .hbm_ready(hbm_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected {last,data} queued on accept, compared on pop
    always @(negedge clk) begin
        logic [256:0] e;
        if (rst) begin
            sb.delete();
            bidx = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_unexpected", out_valid, 0);
                else begin
                    e = sb.pop_front();
                    check("sb_data", out_data, {1'b0, e[255:0]});
                    check("sb_last", out_last, e[256]);
                end
            end
            if (hbm_valid && hbm_ready) begin
                sb.push_back({bidx == 3, hbm_dq});
                bidx = (bidx + 1) % 4;
            end
            if (!rx_enable) bidx = 0;
        end
    end

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hbm_ready) break;
        end
        check(tag, hbm_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [255:0] d);
        logic ok;
        ok = 1'b0;
        hbm_valid = 1'b1;
        hbm_dq = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = hbm_ready;
            @(posedge clk); #1;
        end
        hbm_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, k;
        logic got;
        rst = 1'b1; rx_enable = 1'b0; hbm_valid = 1'b1; hbm_dq = '0; out_ready = 1'b0;
`ifdef HBM_RX_PARITY_EN
        hbm_parity = 1'b0;
`endif
        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t1_ready", hbm_ready, 0);
        check("t1_out_valid", out_valid, 0);
        check("t1_out_last", out_last, 0);
        check("t1_busy", busy, 0);
        check("t1_beat_count", beat_count, 0);
`ifdef HBM_RX_PARITY_EN
        check("t1_perr", parity_err_count, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0; hbm_valid = 1'b0; rx_enable = 1'b1; out_ready = 1'b1;
        // T2 stream with one-cycle latency
        wait_ready("t2_wait_ready");
        for (int i = 1; i <= 4; i++) begin
            hbm_valid = 1'b1;
            hbm_dq = 256'(i);
            @(negedge clk);
            check("t2_ready", hbm_ready, 1);
            if (i > 1) begin
                check("t2_lat_valid", out_valid, 1);
                check("t2_lat_data", out_data, 257'(i - 1));
            end
            @(posedge clk); #1;
        end
        hbm_valid = 1'b0;
        @(negedge clk);
        check("t2_lat_data4", out_data, 257'(4));
        check("t2_last4", out_last, 1);
        check("t2_beat_count", beat_count, 4);
        @(posedge clk); #1;
        // T3 fill to full, single pop, refill
        out_ready = 1'b0; k = 1; acc = 0;
        hbm_valid = 1'b1; hbm_dq = 256'(k);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            got = hbm_valid && hbm_ready;
            if (got) acc++;
            @(posedge clk); #1;
            if (got) begin
                k++;
                hbm_dq = 256'(k);
            end
        end
        check("t3_accepted", 257'(acc), 8);
        @(negedge clk);
        check("t3_full_ready", hbm_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_pop_cycle", hbm_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t3_ready_after_pop", hbm_ready, 1);
        @(posedge clk); #1;
        hbm_valid = 1'b0;
        @(negedge clk);
        check("t3_full_again", hbm_ready, 0);
        check("t3_beat_count", beat_count, 13);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        check("t3_drained", 257'(sb.size()), 0);
        @(posedge clk); #1;
        // Disable mid-burst so the next stream restarts at burst index 0
        rx_enable = 1'b0;
        wait_idle("t4_pre_idle");
        rx_enable = 1'b1;
        wait_ready("t4_pre_ready");
        // T4 drain of a partial burst
        out_ready = 1'b0;
        send(256'hA0); send(256'hA1); send(256'hA2);
        rx_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4_ready_off", hbm_ready, 0);
        check("t4_busy", busy, 1);
        check("t4_buffered", out_valid, 1);
        @(posedge clk); #1;
        hbm_valid = 1'b1; hbm_dq = 256'hBAD; out_ready = 1'b1;
        wait_idle("t4_idle");
        hbm_valid = 1'b0;
        check("t4_sb_empty", 257'(sb.size()), 0);
        check("t4_out_valid", out_valid, 0);
        rx_enable = 1'b1;
        wait_ready("t4_reenable");
        send(256'hC0); send(256'hC1); send(256'hC2); send(256'hC3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t4_beat_count", beat_count, 20);
        @(posedge clk); #1;
        // T5 reset with beats buffered
        out_ready = 1'b0;
        send(256'hD0); send(256'hD1); send(256'hD2); send(256'hD3); send(256'hD4);
        @(negedge clk);
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_count", beat_count, 25);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("t5_out_valid", out_valid, 0);
        check("t5_beat_count", beat_count, 0);
        check("t5_ready", hbm_ready, 0);
        check("t5_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_old", out_valid, 0);
        end
        @(posedge clk); #1;
        wait_ready("t5_ready_again");
        send(256'hF0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_beat_count_after", beat_count, 1);
        @(posedge clk); #1;
`ifdef HBM_RX_PARITY_EN
        // T6 parity errors counted, beats still delivered
        hbm_parity = 1'b0;
        send(256'h1);
        @(negedge clk);
        check("t6_perr_bad", parity_err_count, 1);
        @(posedge clk); #1;
        hbm_parity = 1'b1;
        send(256'h1);
        @(negedge clk);
        check("t6_perr_good", parity_err_count, 1);
        @(posedge clk); #1;
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_sb_empty", 257'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
